clock_div_multi: RTL and testbench

- Multi-channel, runtime-programmable integer clock divider driven from the 100 MHz board clock.
- Each channel produces a divided clock (high phase = ceil(D/2) cycles) and a one-cycle tick pulse per period.
- Divisor changes take effect only on period boundaries, so the output stays glitch-free.
- Feeds the SPI/accelerometer and display timing blocks: one instance replaces per-frequency dividers.

---
 rtl/clock_div_multi.sv | 115 +++++++++++
 tb/tb_clock_div_multi.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/clock_div_multi.sv
// clock_div_multi: multi-channel, runtime-programmable integer clock divider.
// Each channel turns CLK100MHZ into a divided clock with period D cycles,
// high for ceil(D/2) and low for floor(D/2), plus a one-cycle tick at every
// period start. A new divisor is only adopted on a period boundary (or at
// channel start), so the divided clock never glitches.
//
// Load interface: div_load[i] is a one-cycle strobe with no ready side; the
// divider always accepts it. The value on slice i of div_val is sampled in
// the same cycle. If that cycle is a period boundary or a channel start, the
// value becomes the active divisor immediately. Otherwise it is held as
// pending (div_pending[i]=1) until the next boundary. A later strobe before
// that boundary replaces the pending value. Values 0 and 1 are stored as 2.
module clock_div_multi #(
  parameter int NUM_CH      = 4,
  parameter int CW          = 8,
  parameter int DEFAULT_DIV = 25
) (
  input  logic                 CLK100MHZ,
  input  logic                 reset,
  input  logic [NUM_CH-1:0]    ch_en,
  input  logic [NUM_CH*CW-1:0] div_val,
  input  logic [NUM_CH-1:0]    div_load,
  output logic [NUM_CH-1:0]    clk_out,
  output logic [NUM_CH-1:0]    tick,
  output logic [NUM_CH-1:0]    div_pending
);

  localparam logic [CW-1:0] DEF_DIV = CW'(DEFAULT_DIV);
  localparam logic [CW-1:0] MIN_DIV = CW'(2);
  localparam logic [CW-1:0] ONE     = CW'(1);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      // Channel state
      logic [CW-1:0] cnt;
      logic [CW-1:0] act_div;
      logic [CW-1:0] pend_div;
      logic          pend_valid;
      logic          running;
      logic          clk_q;
      logic          tick_q;

      // Derived values for this cycle
      logic [CW-1:0] ld_raw;
      logic [CW-1:0] ld_val;
      logic [CW-1:0] half;
      logic [CW-1:0] cnt_inc;
      logic [CW-1:0] next_div;
      logic          at_boundary;

      // Clamp the loaded value, compute the high-phase length and pick the
      // divisor a new period will use (fresh load beats older pending value)
      always_comb begin
        ld_raw      = div_val[gi*CW +: CW];
        ld_val      = (ld_raw < MIN_DIV) ? MIN_DIV : ld_raw;
        // (act_div+1)>>1 written so it cannot overflow at act_div = 2^CW-1
        half        = (act_div >> 1) + {{(CW-1){1'b0}}, act_div[0]};
        cnt_inc     = cnt + ONE;
        at_boundary = (cnt == (act_div - ONE));
        if (div_load[gi]) begin
          next_div = ld_val;
        end else if (pend_valid) begin
          next_div = pend_div;
        end else begin
          next_div = act_div;
        end
      end

      // Per-channel counter, divisor hand-over and registered outputs
      always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
          cnt        <= '0;
          act_div    <= DEF_DIV;
          pend_div   <= DEF_DIV;
          pend_valid <= 1'b0;
          running    <= 1'b0;
          clk_q      <= 1'b0;
          tick_q     <= 1'b0;
        end else if (!ch_en[gi]) begin
          // Stopped: outputs held low, a pending divisor survives the pause
          running <= 1'b0;
          cnt     <= '0;
          clk_q   <= 1'b0;
          tick_q  <= 1'b0;
          if (div_load[gi]) begin
            pend_div   <= ld_val;
            pend_valid <= 1'b1;
          end
        end else if (!running || at_boundary) begin
          // Period start: adopt the newest divisor and raise clk/tick
          running    <= 1'b1;
          cnt        <= '0;
          clk_q      <= 1'b1;
          tick_q     <= 1'b1;
          act_div    <= next_div;
          pend_valid <= 1'b0;
        end else begin
          cnt    <= cnt_inc;
          clk_q  <= (cnt_inc < half);
          tick_q <= 1'b0;
          if (div_load[gi]) begin
            pend_div   <= ld_val;
            pend_valid <= 1'b1;
          end
        end
      end

      assign clk_out[gi]     = clk_q;
      assign tick[gi]        = tick_q;
      assign div_pending[gi] = pend_valid;
    end
  endgenerate

endmodule

// File: tb/tb_clock_div_multi.sv
// Directed testbench for clock_div_multi: waveform shape per divisor,
// boundary-aligned divisor changes, clamping, enable and reset behaviour.
module tb_clock_div_multi;

  localparam int NUM_CH = 4;
  localparam int CW     = 8;
  localparam int BOUND  = 600;

  logic                 CLK100MHZ = 1'b0;
  logic                 reset;
  logic [NUM_CH-1:0]    ch_en;
  logic [NUM_CH*CW-1:0] div_val;
  logic [NUM_CH-1:0]    div_load;
  logic [NUM_CH-1:0]    clk_out;
  logic [NUM_CH-1:0]    tick;
  logic [NUM_CH-1:0]    div_pending;

  int checks = 0;
  int errors = 0;

  clock_div_multi #(
    .NUM_CH(NUM_CH),
    .CW(CW),
    .DEFAULT_DIV(25)
  ) dut (
    .CLK100MHZ(CLK100MHZ),
    .reset(reset),
    .ch_en(ch_en),
    .div_val(div_val),
    .div_load(div_load),
    .clk_out(clk_out),
    .tick(tick),
    .div_pending(div_pending)
  );

  // Clock: 100 MHz
  always #5 CLK100MHZ = ~CLK100MHZ;

  // Samples and drives both happen on the falling edge
  task automatic step();
    @(negedge CLK100MHZ);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Current sample is the first high cycle of a period; count high, low and
  // ticks until the next rise
  task automatic count_from_rise(input int ch, input int ehi, input int elo, input string tag);
    int hi;
    int lo;
    int tk;
    hi = 0;
    lo = 0;
    tk = 0;
    while (clk_out[ch] === 1'b1 && hi < BOUND) begin
      hi++;
      if (tick[ch] === 1'b1) tk++;
      step();
    end
    while (clk_out[ch] === 1'b0 && lo < BOUND) begin
      lo++;
      if (tick[ch] === 1'b1) tk++;
      step();
    end
    check({tag, "_high"}, hi, ehi);
    check({tag, "_low"}, lo, elo);
    check({tag, "_ticks"}, tk, 1);
  endtask

  // Skip to the next rise of the channel, then measure one period
  task automatic measure(input int ch, input int ehi, input int elo, input string tag);
    int n;
    n = 0;
    while (clk_out[ch] !== 1'b0 && n < BOUND) begin step(); n++; end
    while (clk_out[ch] !== 1'b1 && n < 2*BOUND) begin step(); n++; end
    check({tag, "_found_rise"}, (n < 2*BOUND), 1);
    check({tag, "_rise_tick"}, tick[ch], 1);
    count_from_rise(ch, ehi, elo, tag);
  endtask

  // Reset everything with all channels off
  task automatic do_reset();
    reset    = 1'b1;
    ch_en    = '0;
    div_load = '0;
    step();
    reset = 1'b0;
  endtask

  initial begin
    int n;
    int bad;

    reset    = 1'b1;
    ch_en    = '0;
    div_val  = '0;
    div_load = '0;
    repeat (3) step();
    reset = 1'b0;
    step();

    // Reset state
    check("rst_clk_out", clk_out, 0);
    check("rst_tick", tick, 0);
    check("rst_pending", div_pending, 0);

    // Default divisor 25 on channel 0: tick and rise one edge after enable
    ch_en = 4'b0001;
    step();
    check("start_tick", tick[0], 1);
    check("start_clk", clk_out[0], 1);
    count_from_rise(0, 13, 12, "d25_p1");
    count_from_rise(0, 13, 12, "d25_p2");

    // Load 2/3/4/255: ch1-3 start with the load, ch0 running -> pending
    div_val  = {8'd255, 8'd4, 8'd3, 8'd2};
    ch_en    = 4'hf;
    div_load = 4'hf;
    step();
    div_load = '0;
    check("multi_pending", div_pending, 4'b0001);
    check("multi_tick", tick, 4'b1110);
    measure(0, 1, 1, "ch0_d2");
    check("multi_pend_clr", div_pending, 0);
    measure(1, 2, 1, "ch1_d3");
    measure(2, 2, 2, "ch2_d4");
    measure(3, 128, 127, "ch3_d255");
    measure(0, 1, 1, "ch0_d2_again");

    // Load D=10 at cnt=5 of a D=25 period
    do_reset();
    ch_en = 4'b0001;
    step();
    check("d10_start_tick", tick[0], 1);
    repeat (5) step();
    div_val[7:0] = 8'd10;
    div_load     = 4'b0001;
    step();
    div_load = '0;
    check("d10_pending_set", div_pending[0], 1);
    n   = 6;
    bad = 0;
    while (tick[0] !== 1'b1 && n < BOUND) begin
      if (div_pending[0] !== 1'b1) bad++;
      step();
      n++;
    end
    check("d10_old_period_len", n, 25);
    check("d10_pending_held", bad, 0);
    check("d10_pending_clr", div_pending[0], 0);
    count_from_rise(0, 5, 5, "d10_p1");
    count_from_rise(0, 5, 5, "d10_p2");

    // Load D=8 exactly at the boundary cycle (cnt==24)
    do_reset();
    ch_en = 4'b0001;
    step();
    repeat (24) step();
    div_val[7:0] = 8'd8;
    div_load     = 4'b0001;
    step();
    div_load = '0;
    check("d8_bnd_tick", tick[0], 1);
    check("d8_bnd_no_pending", div_pending[0], 0);
    count_from_rise(0, 4, 4, "d8");

    // Clamping: 0 and 1 behave as 2
    div_val[7:0] = 8'd0;
    div_load     = 4'b0001;
    step();
    div_load = '0;
    check("d0_pending", div_pending[0], 1);
    measure(0, 1, 1, "d0_clamp");
    div_val[7:0] = 8'd1;
    div_load     = 4'b0001;
    step();
    div_load = '0;
    measure(0, 1, 1, "d1_clamp");

    // Disable mid-high phase, then re-enable
    do_reset();
    ch_en = 4'b0001;
    step();
    repeat (4) step();
    check("dis_before_clk", clk_out[0], 1);
    ch_en = '0;
    step();
    check("dis_clk", clk_out[0], 0);
    check("dis_tick", tick[0], 0);
    repeat (3) step();
    check("dis_hold_clk", clk_out[0], 0);
    ch_en = 4'b0001;
    step();
    check("reen_tick", tick[0], 1);
    check("reen_clk", clk_out[0], 1);
    count_from_rise(0, 13, 12, "reen");

    // Reset mid-period with a pending D=10
    do_reset();
    ch_en = 4'b0001;
    step();
    repeat (3) step();
    div_val[7:0] = 8'd10;
    div_load     = 4'b0001;
    step();
    div_load = '0;
    check("rst_mid_pending_set", div_pending[0], 1);
    reset = 1'b1;
    ch_en = '0;
    step();
    reset = 1'b0;
    check("rst_mid_clk", clk_out, 0);
    check("rst_mid_tick", tick, 0);
    check("rst_mid_pending", div_pending, 0);
    step();
    ch_en = 4'b0001;
    step();
    check("post_rst_tick", tick[0], 1);
    count_from_rise(0, 13, 12, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
